// File: rtl/fetch_pcgen_pkg.sv
// Shared types for the fetch next-PC generator: address width, FSM states, prediction payload.
package fetch_pcgen_pkg;

    localparam int unsigned ADDR_LEN = 32;
    localparam int unsigned BUB_W    = 2;

    typedef enum logic [1:0] {
        PCG_IDLE  = 2'd0,
        PCG_RUN   = 2'd1,
        PCG_HOLD  = 2'd2,
        PCG_FLUSH = 2'd3
    } pcg_state_e;

    typedef struct packed {
        logic                taken;
        logic [ADDR_LEN-1:0] target;
    } pred_s;

endpackage

// File: rtl/pcgen_npc_sel.sv
// Next-PC priority mux: redirect, then BTB target (RUN only), then aligned sequential +8.
module pcgen_npc_sel
    import fetch_pcgen_pkg::*;
(
    input  logic                redirect,
    input  logic [ADDR_LEN-1:0] redirect_pc,
    input  logic                btb_hit,
    input  logic [ADDR_LEN-1:0] btb_jmpaddr,
    input  logic                in_run,
    input  logic [ADDR_LEN-1:0] pc,
    output logic [ADDR_LEN-1:0] npc_c
);

    logic [ADDR_LEN-1:0] seq_pc;

    // Packet base is 8-byte aligned; the add wraps naturally at the top of the address space.
    assign seq_pc = (pc & ~ADDR_LEN'(7)) + ADDR_LEN'(8);

    always_comb begin
        npc_c = seq_pc;
        if (redirect) begin
            npc_c = redirect_pc;
        end else if (btb_hit && in_run) begin
            npc_c = btb_jmpaddr;
        end
    end

endmodule

// File: rtl/fetch_pcgen.sv
// Fetch-stage PC generator feeding the BTB: FSM, fetch PC and prediction registers.
// Optional build macro PCGEN_PERF_EN adds fetch/redirect/BTB-hit performance counters.
module fetch_pcgen
    import fetch_pcgen_pkg::*;
#(
    parameter logic [ADDR_LEN-1:0] ENTRY_PC      = '0,
    parameter int unsigned         FLUSH_BUBBLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_LEN-1:0] redirect_pc,
    input  logic                btb_hit,
    input  logic [ADDR_LEN-1:0] btb_jmpaddr,
    output logic [ADDR_LEN-1:0] pc,
    output logic                invalid2,
    output logic                fetch_valid,
    output logic                pred_taken,
    output logic [ADDR_LEN-1:0] pred_target,
`ifdef PCGEN_PERF_EN
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_redirect_cnt,
    output logic [31:0]         perf_btbhit_cnt,
`endif
    output logic [ADDR_LEN-1:0] npc
);

    pcg_state_e         state, state_nxt;
    logic [BUB_W-1:0]   bub_cnt, bub_cnt_nxt;
    logic [ADDR_LEN-1:0] pc_nxt;
    pred_s              pred, pred_nxt;
    logic               fetch_valid_nxt;
    logic               in_run;
    logic               btb_apply;

    assign in_run    = (state == PCG_RUN);
    assign btb_apply = in_run && !redirect && !stall && btb_hit;

    pcgen_npc_sel u_npc_sel (
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .btb_hit     (btb_hit),
        .btb_jmpaddr (btb_jmpaddr),
        .in_run      (in_run),
        .pc          (pc),
        .npc_c       (npc)
    );

    // State and packet registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= PCG_IDLE;
            bub_cnt     <= '0;
            pc          <= ENTRY_PC;
            pred        <= '0;
            fetch_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            bub_cnt     <= bub_cnt_nxt;
            pc          <= pc_nxt;
            pred        <= pred_nxt;
            fetch_valid <= fetch_valid_nxt;
        end
    end

    // Next-state, next-PC and prediction update
    always_comb begin
        state_nxt   = state;
        bub_cnt_nxt = bub_cnt;
        pc_nxt      = pc;
        pred_nxt    = pred;

        case (state)
            PCG_IDLE: begin
                if (start) state_nxt = PCG_RUN;
            end
            PCG_RUN: begin
                if (stall) begin
                    state_nxt = PCG_HOLD;
                end else begin
                    pc_nxt          = npc;
                    pred_nxt.taken  = btb_hit;
                    pred_nxt.target = btb_hit ? btb_jmpaddr : '0;
                end
            end
            PCG_HOLD: begin
                // Released packet was fetched before the stall; its BTB read is stale.
                if (!stall) begin
                    state_nxt = PCG_RUN;
                    pc_nxt    = npc;
                    pred_nxt  = '0;
                end
            end
            PCG_FLUSH: begin
                if (bub_cnt == '0) begin
                    state_nxt = stall ? PCG_HOLD : PCG_RUN;
                end else begin
                    bub_cnt_nxt = bub_cnt - BUB_W'(1);
                end
            end
            default: state_nxt = PCG_IDLE;
        endcase

        // Redirect overrides everything; IDLE only takes the new PC.
        if (redirect) begin
            pc_nxt   = redirect_pc;
            pred_nxt = '0;
            if (state != PCG_IDLE) begin
                state_nxt   = PCG_FLUSH;
                bub_cnt_nxt = BUB_W'(FLUSH_BUBBLES - 1);
            end
        end

        fetch_valid_nxt = (state_nxt == PCG_RUN) || (state_nxt == PCG_HOLD);
    end

    assign invalid2    = pc[2];
    assign pred_taken  = pred.taken;
    assign pred_target = pred.target;

`ifdef PCGEN_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt    <= '0;
            perf_redirect_cnt <= '0;
            perf_btbhit_cnt   <= '0;
        end else begin
            if (fetch_valid && !stall) perf_fetch_cnt    <= perf_fetch_cnt + 32'd1;
            if (redirect)              perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            if (btb_apply)             perf_btbhit_cnt   <= perf_btbhit_cnt + 32'd1;
        end
    end
`else
    logic unused_btb_apply;
    assign unused_btb_apply = btb_apply;
`endif

endmodule

// File: tb/tb_fetch_pcgen.sv
// Self-checking bench for fetch_pcgen: directed test-plan steps followed by random traffic against a packet-level model.
module tb_fetch_pcgen;
    import fetch_pcgen_pkg::*;

    localparam int unsigned FB = 2;

    logic        clk = 1'b0;
    logic        reset, start, stall, redirect, btb_hit;
    logic [31:0] redirect_pc, btb_jmpaddr;
    logic [31:0] pc, pred_target, npc;
    logic        invalid2, fetch_valid, pred_taken;
`ifdef PCGEN_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_redirect_cnt, perf_btbhit_cnt;
`endif

    always #5 clk = ~clk;

    fetch_pcgen #(.ENTRY_PC(32'h0), .FLUSH_BUBBLES(FB)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .btb_hit     (btb_hit),
        .btb_jmpaddr (btb_jmpaddr),
        .pc          (pc),
        .invalid2    (invalid2),
        .fetch_valid (fetch_valid),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
`ifdef PCGEN_PERF_EN
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_redirect_cnt (perf_redirect_cnt),
        .perf_btbhit_cnt   (perf_btbhit_cnt),
`endif
        .npc         (npc)
    );

    // Packet-level model: active = started, bub = invalid cycles left, held = current packet not freshly fetched.
    logic [31:0] m_pc, m_pt;
    bit          m_pv, m_active, m_held;
    int          m_bub;
    logic [31:0] m_fc, m_rc, m_hc;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_npc();
        if (redirect) return redirect_pc;
        if (m_active && m_bub == 0 && !m_held && btb_hit) return btb_jmpaddr;
        return (m_pc & 32'hFFFF_FFF8) + 32'd8;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_pt = 32'h0; m_pv = 0;
        m_active = 0; m_held = 0; m_bub = 0;
        m_fc = 0; m_rc = 0; m_hc = 0;
    endtask

    task automatic model_step();
        if (m_active && m_bub == 0 && !stall) m_fc++;
        if (redirect) begin
            m_rc++;
            m_pc = redirect_pc; m_pv = 0; m_pt = 0;
            if (m_active) begin m_bub = FB; m_held = 0; end
        end else if (!m_active) begin
            if (start) begin m_active = 1; m_held = 0; end
        end else if (m_bub > 0) begin
            m_bub--;
            if (m_bub == 0) m_held = stall;
        end else if (stall) begin
            m_held = 1;
        end else begin
            if (!m_held && btb_hit) begin
                m_pc = btb_jmpaddr; m_pv = 1; m_pt = btb_jmpaddr; m_hc++;
            end else begin
                m_pc = (m_pc & 32'hFFFF_FFF8) + 32'd8; m_pv = 0; m_pt = 0;
            end
            m_held = 0;
        end
    endtask

    task automatic check_outputs();
        chk("pc", pc, m_pc);
        chk("fetch_valid", 32'(fetch_valid), 32'(m_active && m_bub == 0));
        chk("invalid2", 32'(invalid2), 32'(m_pc[2]));
        chk("pred_taken", 32'(pred_taken), 32'(m_pv));
        chk("pred_target", pred_target, m_pt);
`ifdef PCGEN_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, m_fc);
        chk("perf_redirect", perf_redirect_cnt, m_rc);
        chk("perf_btbhit", perf_btbhit_cnt, m_hc);
`endif
    endtask

    task automatic cyc(input logic st, input logic stl, input logic rd, input logic [31:0] rpc,
                       input logic hit, input logic [31:0] jmp);
        @(negedge clk);
        start = st; stall = stl; redirect = rd; redirect_pc = rpc; btb_hit = hit; btb_jmpaddr = jmp;
        #1 chk("npc", npc, m_npc());
        @(posedge clk);
        model_step();
        #1 check_outputs();
    endtask

    task automatic go_to(input logic [31:0] target);
        cyc(1, 0, 1, target, 0, 0);
        for (int i = 0; i < int'(FB); i++) cyc(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0; start = 0; stall = 0; redirect = 0; btb_hit = 0;
        redirect_pc = 0; btb_jmpaddr = 0;
        model_reset();
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        chk("rst_pred_taken", 32'(pred_taken), 32'h0);
        chk("rst_pred_target", pred_target, 32'h0);
        chk("rst_invalid2", 32'(invalid2), 32'h0);
        @(negedge clk) reset = 1'b1;

        // Sequential fetch from entry
        cyc(1, 0, 0, 0, 0, 0);
        chk("start_valid", 32'(fetch_valid), 32'h1);
        chk("seq0", pc, 32'h0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("seq1", pc, 32'h8);
        cyc(1, 0, 0, 0, 0, 0);
        chk("seq2", pc, 32'h10);

        // BTB taken prediction
        go_to(32'h100);
        cyc(1, 0, 0, 0, 1, 32'h204);
        chk("hit_pc", pc, 32'h204);
        chk("hit_inv2", 32'(invalid2), 32'h1);
        chk("hit_pt", 32'(pred_taken), 32'h1);
        chk("hit_ptgt", pred_target, 32'h204);
        cyc(1, 0, 0, 0, 0, 0);
        chk("after_hit_pc", pc, 32'h208);

        // Stall hold and release; hit during HOLD ignored
        go_to(32'h40);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 1, 32'h999);
            chk("stall_pc", pc, 32'h40);
            chk("stall_valid", 32'(fetch_valid), 32'h1);
        end
        cyc(1, 0, 0, 0, 1, 32'h999);
        chk("release_pc", pc, 32'h48);

        // Redirect wins over stall
        cyc(1, 1, 1, 32'h3000, 0, 0);
        chk("redir_pc", pc, 32'h3000);
        chk("redir_valid", 32'(fetch_valid), 32'h0);
        chk("redir_pt", 32'(pred_taken), 32'h0);
        for (int i = 0; i < int'(FB); i++) cyc(1, 0, 0, 0, 0, 0);
        chk("flush_exit_valid", 32'(fetch_valid), 32'h1);

        // Wrap at top of address space
        go_to(32'hFFFF_FFF8);
        cyc(1, 0, 0, 0, 0, 0);
        chk("wrap_pc", pc, 32'h0);

        // Async reset in the middle of FLUSH
        cyc(1, 0, 1, 32'h500, 0, 0);
        @(negedge clk);
        start = 0; redirect = 0;
        #1 reset = 1'b0;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_valid", 32'(fetch_valid), 32'h0);
        model_reset();
        @(negedge clk) reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        chk("idle_hold_valid", 32'(fetch_valid), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                $urandom(), ($urandom_range(0, 2) == 0), $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pcgen.md
Name: fetch_pcgen

Overview:
Fetch-stage next-PC generator that sits directly upstream of the branch target buffer. It drives the fetch PC and the second-slot invalid flag to the BTB and consumes the BTB's hit and jmpaddr. It also takes stall and mispredict-redirect inputs from the backend. For each fetch packet it emits a valid flag, prediction metadata and a one-cycle post-redirect bubble, all sequenced by a small FSM.

Parameters:
ENTRY_PC, 32'h0000_0000, PC loaded on reset (8-byte aligned)
FLUSH_BUBBLES, 1, number of fetch_valid=0 cycles after a redirect (1..3)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
start  in  1  level; leave IDLE and begin fetching
stall  in  1  backend not ready; hold PC and packet outputs
redirect  in  1  mispredict/exception redirect from execute/commit
redirect_pc  in  `ADDR_LEN  redirect target
btb_hit  in  1  BTB hit for current pc
btb_jmpaddr  in  `ADDR_LEN  BTB predicted target
pc  out  `ADDR_LEN  current fetch PC (to BTB and I-cache)
invalid2  out  1  second instruction slot of packet invalid
fetch_valid  out  1  packet at pc is valid this cycle
pred_taken  out  1  packet predicted taken (registered with the packet)
pred_target  out  `ADDR_LEN  predicted target accompanying pred_taken
npc  out  `ADDR_LEN  combinational next PC (debug/trace)

Behaviour:
- Reset (reset=0, async):
  - pc=ENTRY_PC, state=IDLE, fetch_valid=0, pred_taken=0, pred_target=0, invalid2=ENTRY_PC[2], bubble counter=0.
- FSM states: IDLE, RUN, HOLD, FLUSH.
  - IDLE: fetch_valid=0; start=1 -> RUN next cycle. Redirect in IDLE updates pc and stays IDLE.
  - RUN: fetch_valid=1.
    - stall -> HOLD.
    - redirect -> FLUSH.
    - else advance pc=npc.
  - HOLD: fetch_valid=1, pc/pred outputs frozen.
    - redirect -> FLUSH (redirect wins over stall).
    - stall=0 -> RUN and advance pc=npc.
  - FLUSH: fetch_valid=0; counter loads FLUSH_BUBBLES-1 on entry.
    - Exit to RUN (or HOLD if stall) when counter==0.
    - A new redirect while in FLUSH reloads pc and restarts the counter.
- npc priority:
  1. redirect -> redirect_pc.
  2. btb_hit and state RUN -> btb_jmpaddr.
  3. otherwise {pc[ADDR_LEN-1:3],3'b000} + 8.
- Redirect is sampled in any state including HOLD. pc=redirect_pc on the next edge, latency 1.
- invalid2 = pc[2], combinational from the registered pc (packet begins in slot 2).
- pred_taken/pred_target are registered with the pc advance: set to btb_hit/btb_jmpaddr when advancing from RUN, cleared on redirect.
- Arithmetic: pc+8 wraps modulo 2^ADDR_LEN with no saturation. 32'hFFFF_FFF8 advances to 0.
- redirect_pc and btb_jmpaddr are used unaligned as given; bit 2 selects invalid2.
- btb_hit is ignored outside RUN. The BTB read is stale across a stall and redirect.

Optional Feature:
PCGEN_PERF_EN.
- Defined: adds 32-bit output counters perf_fetch_cnt (cycles with fetch_valid & ~stall), perf_redirect_cnt (redirects accepted) and perf_btbhit_cnt (taken BTB predictions applied).
  - Counters reset to 0 and wrap.
- Undefined: counter ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared constants header (constants.vh): ADDR_LEN and FSM state encodings PCG_IDLE/RUN/HOLD/FLUSH (2-bit).
- One sub-module: pcgen_npc_sel, the combinational next-PC priority mux plus aligned +8 adder. The FSM and registers stay in fetch_pcgen.

Test Plan:
- Reset to 0, release, start=1, no hits, no stall -> pc sequence 0x0,0x8,0x10; fetch_valid=1 from the second post-start cycle.
- In RUN at pc=0x100 with btb_hit=1, btb_jmpaddr=0x204 -> next pc=0x204, invalid2=1, pred_taken=1, pred_target=0x204; following pc=0x208.
- stall=1 for 3 cycles at pc=0x40 -> pc held at 0x40, fetch_valid=1 throughout; stall drop -> pc=0x48.
- redirect=1, redirect_pc=0x3000 while stall=1 -> pc=0x3000 next cycle, fetch_valid=0 for FLUSH_BUBBLES cycles, pred_taken=0, then RUN.
- pc=32'hFFFF_FFF8, no hit -> pc wraps to 0x0; async reset asserted mid-FLUSH -> pc=ENTRY_PC, state IDLE immediately.
- PCGEN_PERF_EN defined: 5 fetch cycles, 1 redirect, 2 applied hits -> counters 5/1/2; undefined build compiles without the ports.
